// File: rtl/harvos_mpu_pkg.sv
// Shared types for MPU region programming: the region descriptor, the
// permission triple, the response codes and the region-check rule.
package harvos_mpu_pkg;

    localparam int NREG_DEFAULT = 8;

    // {X,W,R}
    typedef logic [2:0] perm_t;

    typedef struct packed {
        logic [2:0]  idx;
        logic [31:0] base;
        logic [31:0] limit;
        perm_t       perm;
        logic        user_ok;
        logic        is_ispace;
    } region_t;

    typedef enum logic [1:0] {
        RSP_OK        = 2'd0,
        RSP_LOCKED    = 2'd1,
        RSP_BAD_IDX   = 2'd2,
        RSP_BAD_RANGE = 2'd3
    } rsp_err_e;

    // Lock dominates, then index range, then an inverted (unsigned) address range.
    function automatic rsp_err_e check_region(input region_t r, input logic lock, input int nreg);
        if (lock) begin
            return RSP_LOCKED;
        end else if (int'(r.idx) >= nreg) begin
            return RSP_BAD_IDX;
        end else if (r.base > r.limit) begin
            return RSP_BAD_RANGE;
        end
        return RSP_OK;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first valid requester found when
// searching upward from ptr_i and wrapping at NREQ.
module rr_arbiter #(
    parameter int NREQ = 3,
    parameter int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] valid_i,
    input  logic [PTRW-1:0] ptr_i,
    output logic [NREQ-1:0] grant_o
);

    logic            found;
    logic [PTRW:0]   cand_w;
    logic [PTRW-1:0] cand;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        cand_w  = '0;
        cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            // ptr + k stays below 2*NREQ, so one conditional subtract is the modulo
            cand_w = {1'b0, ptr_i} + (PTRW+1)'(k);
            if (cand_w >= (PTRW+1)'(NREQ)) begin
                cand_w = cand_w - (PTRW+1)'(NREQ);
            end
            cand = cand_w[PTRW-1:0];
            if (!found && valid_i[cand]) begin
                grant_o[cand] = 1'b1;
                found         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mpu_prog_arbiter.sv
// Arbitrates region-write requests from boot, CSR and debug masters, checks
// them against lock/index/range rules and drives one registered MPU write.
module mpu_prog_arbiter
    import harvos_mpu_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int NREG = NREG_DEFAULT,
    parameter int ERRW = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [3*NREQ-1:0] req_idx,
    input  logic [32*NREQ-1:0] req_base,
    input  logic [32*NREQ-1:0] req_limit,
    input  logic [3*NREQ-1:0] req_perm,
    input  logic [NREQ-1:0]   req_user_ok,
    input  logic [NREQ-1:0]   req_is_ispace,
    input  logic              lock_set,
    output logic              mpu_prog_en,
    output logic [2:0]        mpu_prog_idx,
    output logic [31:0]       mpu_prog_base,
    output logic [31:0]       mpu_prog_limit,
    output logic [2:0]        mpu_prog_perm,
    output logic              mpu_prog_user_ok,
    output logic              mpu_prog_is_ispace,
    output logic              rsp_valid,
    output logic [1:0]        rsp_id,
    output logic [1:0]        rsp_err,
    output logic              locked,
    output logic [ERRW-1:0]   err_cnt
);

    localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

    region_t         req_desc [NREQ];
    logic [NREQ-1:0] grant;
    logic [PTRW-1:0] gnt_idx;
    logic            accept;
    region_t         sel;
    rsp_err_e        chk_err;

    logic [PTRW-1:0] rr_ptr_q, rr_ptr_d;
    logic            locked_q, locked_d;
    logic [ERRW-1:0] err_cnt_q, err_cnt_d;
    logic            prog_en_q, prog_en_d;
    region_t         prog_q, prog_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [1:0]      rsp_id_q, rsp_id_d;
    rsp_err_e        rsp_err_q, rsp_err_d;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_desc
            assign req_desc[gi] = '{
                idx:       req_idx[3*gi +: 3],
                base:      req_base[32*gi +: 32],
                limit:     req_limit[32*gi +: 32],
                perm:      req_perm[3*gi +: 3],
                user_ok:   req_user_ok[gi],
                is_ispace: req_is_ispace[gi]
            };
        end
    endgenerate

    rr_arbiter #(
        .NREQ (NREQ),
        .PTRW (PTRW)
    ) u_rr (
        .valid_i (req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant)
    );

    assign req_ready = rst ? '0 : grant;
    assign accept    = |req_ready;

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                gnt_idx = PTRW'(i);
            end
        end
    end

    assign sel     = req_desc[gnt_idx];
    assign chk_err = check_region(sel, locked_q | lock_set, NREG);

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        locked_d    = locked_q | lock_set;
        err_cnt_d   = err_cnt_q;
        prog_en_d   = 1'b0;
        prog_d      = '0;
        rsp_valid_d = 1'b0;
        rsp_id_d    = 2'd0;
        rsp_err_d   = RSP_OK;
        if (accept) begin
            rr_ptr_d    = (gnt_idx == PTRW'(NREQ-1)) ? '0 : gnt_idx + PTRW'(1);
            rsp_valid_d = 1'b1;
            rsp_id_d    = 2'(gnt_idx);
            rsp_err_d   = chk_err;
            if (chk_err == RSP_OK) begin
                prog_en_d = 1'b1;
                prog_d    = sel;
            end else if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + ERRW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            locked_q    <= 1'b0;
            err_cnt_q   <= '0;
            prog_en_q   <= 1'b0;
            prog_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 2'd0;
            rsp_err_q   <= RSP_OK;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            locked_q    <= locked_d;
            err_cnt_q   <= err_cnt_d;
            prog_en_q   <= prog_en_d;
            prog_q      <= prog_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // A write registered just before rst must never reach the core, so the
    // pulse outputs are also masked while rst is still high.
    assign mpu_prog_en        = prog_en_q & ~rst;
    assign mpu_prog_idx       = rst ? 3'd0  : prog_q.idx;
    assign mpu_prog_base      = rst ? 32'd0 : prog_q.base;
    assign mpu_prog_limit     = rst ? 32'd0 : prog_q.limit;
    assign mpu_prog_perm      = rst ? 3'd0  : prog_q.perm;
    assign mpu_prog_user_ok   = prog_q.user_ok & ~rst;
    assign mpu_prog_is_ispace = prog_q.is_ispace & ~rst;
    assign rsp_valid          = rsp_valid_q & ~rst;
    assign rsp_id             = rst ? 2'd0 : rsp_id_q;
    assign rsp_err            = rst ? 2'd0 : rsp_err_q;
    assign locked             = locked_q;
    assign err_cnt            = err_cnt_q;

endmodule

// File: tb/tb_mpu_prog_arbiter.sv
// Randomized bench for mpu_prog_arbiter: a default instance and a NREG=4/ERRW=2
// instance share stimulus and are compared each cycle against a reference model.
module tb_mpu_prog_arbiter;

    localparam int NREQ = 3;

    logic clk = 1'b0;
    logic rst;
    logic [NREQ-1:0] v;
    logic lock_set;
    logic [2:0]  t_idx   [NREQ];
    logic [31:0] t_base  [NREQ];
    logic [31:0] t_limit [NREQ];
    logic [2:0]  t_perm  [NREQ];
    logic        t_uok   [NREQ];
    logic        t_isp   [NREQ];

    logic [3*NREQ-1:0]  req_idx, req_perm;
    logic [32*NREQ-1:0] req_base, req_limit;
    logic [NREQ-1:0]    req_uok, req_isp;

    assign req_idx   = {t_idx[2], t_idx[1], t_idx[0]};
    assign req_perm  = {t_perm[2], t_perm[1], t_perm[0]};
    assign req_base  = {t_base[2], t_base[1], t_base[0]};
    assign req_limit = {t_limit[2], t_limit[1], t_limit[0]};
    assign req_uok   = {t_uok[2], t_uok[1], t_uok[0]};
    assign req_isp   = {t_isp[2], t_isp[1], t_isp[0]};

    logic [NREQ-1:0] d_ready, s_ready;
    logic d_en, d_uok, d_isp, d_rv, d_locked;
    logic [2:0] d_idx, d_perm;
    logic [31:0] d_base, d_limit;
    logic [1:0] d_rid, d_rerr;
    logic [7:0] d_cnt;
    logic s_en, s_uok, s_isp, s_rv, s_locked;
    logic [2:0] s_idx, s_perm;
    logic [31:0] s_base, s_limit;
    logic [1:0] s_rid, s_rerr;
    logic [1:0] s_cnt;

    mpu_prog_arbiter #(.NREQ(3), .NREG(8), .ERRW(8)) dut (
        .clk(clk), .rst(rst), .req_valid(v), .req_ready(d_ready),
        .req_idx(req_idx), .req_base(req_base), .req_limit(req_limit), .req_perm(req_perm),
        .req_user_ok(req_uok), .req_is_ispace(req_isp), .lock_set(lock_set),
        .mpu_prog_en(d_en), .mpu_prog_idx(d_idx), .mpu_prog_base(d_base),
        .mpu_prog_limit(d_limit), .mpu_prog_perm(d_perm), .mpu_prog_user_ok(d_uok),
        .mpu_prog_is_ispace(d_isp), .rsp_valid(d_rv), .rsp_id(d_rid), .rsp_err(d_rerr),
        .locked(d_locked), .err_cnt(d_cnt)
    );

    mpu_prog_arbiter #(.NREQ(3), .NREG(4), .ERRW(2)) dut_small (
        .clk(clk), .rst(rst), .req_valid(v), .req_ready(s_ready),
        .req_idx(req_idx), .req_base(req_base), .req_limit(req_limit), .req_perm(req_perm),
        .req_user_ok(req_uok), .req_is_ispace(req_isp), .lock_set(lock_set),
        .mpu_prog_en(s_en), .mpu_prog_idx(s_idx), .mpu_prog_base(s_base),
        .mpu_prog_limit(s_limit), .mpu_prog_perm(s_perm), .mpu_prog_user_ok(s_uok),
        .mpu_prog_is_ispace(s_isp), .rsp_valid(s_rv), .rsp_id(s_rid), .rsp_err(s_rerr),
        .locked(s_locked), .err_cnt(s_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference state
    int m_ptr;
    bit m_locked;
    int m_cnt, m_cnt_s;
    // expected registered outputs for the coming cycle
    bit e_en, e_en_s, e_uok, e_isp, e_rv;
    int e_idx, e_perm, e_rid, e_rerr, e_rerr_s;
    logic [31:0] e_base, e_limit;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rule(input int i, input int nreg, input bit lk);
        if (lk) return 1;
        if (int'(t_idx[i]) >= nreg) return 2;
        if (t_base[i] > t_limit[i]) return 3;
        return 0;
    endfunction

    task automatic clear_exp();
        e_en = 0; e_en_s = 0; e_uok = 0; e_isp = 0; e_rv = 0;
        e_idx = 0; e_perm = 0; e_rid = 0; e_rerr = 0; e_rerr_s = 0;
        e_base = '0; e_limit = '0;
    endtask

    // Inputs are set just after a posedge; this checks mid-cycle, advances the model,
    // and returns just after the next posedge.
    task automatic step();
        int g;
        int er, er_s;
        logic [NREQ-1:0] exp_ready;
        #2;
        g = -1;
        if (!rst) begin
            for (int k = 0; k < NREQ; k++) begin
                if (g < 0 && v[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
            end
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        chk("ready", 64'(d_ready), 64'(exp_ready));
        chk("ready_small", 64'(s_ready), 64'(exp_ready));
        if (!rst) begin
            chk("prog_en", 64'(d_en), 64'(e_en));
            chk("prog_idx", 64'(d_idx), 64'(e_idx));
            chk("prog_base", 64'(d_base), 64'(e_base));
            chk("prog_limit", 64'(d_limit), 64'(e_limit));
            chk("prog_perm", 64'(d_perm), 64'(e_perm));
            chk("prog_user_ok", 64'(d_uok), 64'(e_uok));
            chk("prog_is_ispace", 64'(d_isp), 64'(e_isp));
            chk("rsp_valid", 64'(d_rv), 64'(e_rv));
            chk("rsp_id", 64'(d_rid), 64'(e_rid));
            chk("rsp_err", 64'(d_rerr), 64'(e_rerr));
            chk("locked", 64'(d_locked), 64'(m_locked));
            chk("err_cnt", 64'(d_cnt), 64'(m_cnt));
            chk("small_prog_en", 64'(s_en), 64'(e_en_s));
            chk("small_rsp_valid", 64'(s_rv), 64'(e_rv));
            chk("small_rsp_err", 64'(s_rerr), 64'(e_rerr_s));
            chk("small_err_cnt", 64'(s_cnt), 64'(m_cnt_s));
        end
        clear_exp();
        if (rst) begin
            m_ptr = 0; m_locked = 0; m_cnt = 0; m_cnt_s = 0;
        end else begin
            if (g >= 0) begin
                er   = rule(g, 8, m_locked | lock_set);
                er_s = rule(g, 4, m_locked | lock_set);
                e_rv = 1; e_rid = g; e_rerr = er; e_rerr_s = er_s;
                if (er == 0) begin
                    e_en = 1; e_idx = t_idx[g]; e_base = t_base[g]; e_limit = t_limit[g];
                    e_perm = t_perm[g]; e_uok = t_uok[g]; e_isp = t_isp[g];
                end else if (m_cnt < 255) begin
                    m_cnt++;
                end
                if (er_s == 0) e_en_s = 1;
                else if (m_cnt_s < 3) m_cnt_s++;
                m_ptr = (g + 1) % NREQ;
                $display("txn t=%0t req=%0d idx=%0d base=%08h limit=%08h err=%0d err_small=%0d",
                         $time, g, t_idx[g], t_base[g], t_limit[g], er, er_s);
            end
            if (lock_set) m_locked = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input int idx, input logic [31:0] base,
                           input logic [31:0] limit, input int perm);
        t_idx[i] = 3'(idx); t_base[i] = base; t_limit[i] = limit;
        t_perm[i] = 3'(perm); t_uok[i] = 1'b0; t_isp[i] = 1'b0;
    endtask

    task automatic rand_req(input int i, input bit force_ok);
        logic [31:0] b;
        b = $urandom;
        t_idx[i]  = force_ok ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
        t_base[i] = b;
        if (force_ok) t_limit[i] = b | 32'h0000_0FFF;
        else t_limit[i] = ($urandom_range(0, 3) == 0) ? $urandom : b + $urandom_range(0, 4096);
        t_perm[i] = 3'($urandom_range(0, 7));
        t_uok[i]  = 1'($urandom_range(0, 1));
        t_isp[i]  = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset(input int n);
        rst = 1; v = '0; lock_set = 0;
        for (int c = 0; c < n; c++) step();
        rst = 0;
    endtask

    initial begin
        m_ptr = 0; m_locked = 0; m_cnt = 0; m_cnt_s = 0;
        clear_exp();
        for (int i = 0; i < NREQ; i++) set_req(i, 0, 0, 0, 0);
        rst = 1; v = '0; lock_set = 0;
        @(posedge clk);
        #1;
        do_reset(3);
        step();

        // single request from boot
        set_req(0, 0, 32'h0, 32'h0000_FFFF, 3'b101);
        v = 3'b001;
        step();
        v = '0;
        step();
        step();

        // all three valid from reset: 0,1,2,0,1,2 back to back
        do_reset(2);
        v = 3'b111;
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < NREQ; i++) rand_req(i, 1'b1);
            step();
        end
        v = '0;
        step();

        // BAD_IDX only for the small instance, BAD_RANGE for both, saturating small counter
        set_req(0, 7, 32'h0, 32'h10, 3'b001);
        v = 3'b001;
        step();
        set_req(1, 1, 32'h2000_0000, 32'h1FFF_FFFF, 3'b011);
        v = 3'b010;
        step();
        set_req(2, 5, 32'h0000_0100, 32'h0000_0200, 3'b111);
        v = 3'b100;
        step();
        set_req(0, 2, 32'h8000_0000, 32'h7FFF_FFFF, 3'b001);
        v = 3'b001;
        for (int c = 0; c < 3; c++) step();
        v = '0;
        step();

        // random traffic with occasional reset
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) rand_req(i, 1'b0);
            v   = 3'($urandom_range(0, 7));
            rst = ($urandom_range(0, 63) == 0);
            step();
        end
        rst = 0;
        v = '0;
        step();

        // accept followed immediately by reset is dropped
        do_reset(2);
        set_req(0, 3, 32'h1000, 32'h1FFF, 3'b111);
        v = 3'b001;
        step();
        rst = 1;
        v = '0;
        step();
        rst = 0;
        step();
        v = 3'b111;
        for (int i = 0; i < NREQ; i++) rand_req(i, 1'b1);
        step();

        // lock in the same cycle as a CSR request, then everything rejected
        v = 3'b010;
        rand_req(1, 1'b1);
        lock_set = 1;
        step();
        lock_set = 0;
        v = '0;
        step();
        for (int c = 0; c < 40; c++) begin
            for (int i = 0; i < NREQ; i++) rand_req(i, 1'b1);
            v = 3'($urandom_range(0, 7));
            step();
        end
        v = '0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
